module_uart_ctrl_fsm: RTL and testbench
=======================================

Name: module_uart_ctrl_fsm

Overview:
Sequencing controller for the UART control register.
- Watches the register's command bits and launches transmissions on the UART TX engine.
- Captures bytes from the UART RX engine.
- Writes status back into the control register through its FSM write port (we_fsm / instruccion_fsm). That port has priority over the micro write port.
- Sits between the control register, the TX engine and the RX engine. It is the only agent that clears SEND and sets NEW_RX.

Parameters:
- DATA_W, 32, control register width
- SEND_BIT, 0, bit index: micro sets to request transmission; FSM clears when done
- NEW_RX_BIT, 1, bit index: FSM sets when a byte is captured; micro clears
- OVR_BIT, 2, bit index: FSM sets on RX overrun
- ERR_BIT, 3, bit index: FSM sets on TX timeout (only with the optional feature)
- TIMEOUT_CYCLES, 200000, max cycles from tx_start_o to tx_done_i

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  synchronous reset, active-low
- ctrl_reg_i  in  DATA_W  current control register contents
- tx_done_i  in  1  one-cycle pulse from TX engine, frame finished
- rx_valid_i  in  1  one-cycle pulse from RX engine, byte received
- rx_data_i  in  8  received byte, valid with rx_valid_i
- tx_start_o  out  1  one-cycle pulse that starts a TX frame
- we_fsm_o  out  1  FSM write enable to control register
- instruccion_fsm_o  out  DATA_W  value written when we_fsm_o=1
- rx_data_o  out  8  last captured RX byte
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, rst_n_i=0 at a clk_i edge):
  - state=IDLE; tx_start_o=0, we_fsm_o=0, instruccion_fsm_o=0, rx_data_o=0, busy_o=0.
  - rx_pend and ovr_pend cleared.
  - An in-flight TX is abandoned. A later tx_done_i is ignored in IDLE.
- State machine:
  - IDLE: if ctrl_reg_i[SEND_BIT]=1, go to START.
  - START: tx_start_o=1 for exactly this one cycle; go to WAIT.
  - WAIT: on tx_done_i=1, go to CLEAR.
  - CLEAR: one cycle; we_fsm_o=1 with SEND_BIT forced to 0; go to IDLE.
- TX latency:
  - SEND seen in IDLE at cycle N gives tx_start_o at N+1.
  - tx_done_i at cycle M gives the CLEAR write at M+1.
  - The register shows SEND=0 at M+2, when the FSM is back in IDLE, so there is no retrigger on a stale bit.
- RX capture (independent of TX state):
  - rx_valid_i at cycle K: rx_data_o<=rx_data_i; rx_pend=1 at K+1.
  - Write cycle K+1: we_fsm_o=1 with NEW_RX_BIT forced to 1.
  - If ctrl_reg_i[NEW_RX_BIT] was already 1 at K, ovr_pend is also set and OVR_BIT is forced to 1. The new byte overwrites the old one.
- Write merging:
  - we_fsm_o = (state==CLEAR) | rx_pend | ovr_pend (| err_pend).
  - instruccion_fsm_o = ctrl_reg_i with all pending forcings applied in the same cycle. Untouched bits pass through unchanged.
  - Pending flags clear the cycle after their write unless re-armed by a new event in that cycle.
- Simultaneous events:
  - RX during START/WAIT/CLEAR: serviced normally. If it coincides with CLEAR, one merged write clears SEND and sets NEW_RX.
  - A micro write in a cycle with we_fsm_o=1 is lost, because the register gives the FSM priority. Firmware polls busy_o and NEW_RX to avoid this.
- Back-to-back rx_valid_i on consecutive cycles: rx_pend stays 1 and the second byte sets OVR.

Optional Feature:
- UART_CTRL_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without tx_done_i, go to CLEAR and force ERR_BIT=1 alongside SEND=0.
  - The counter resets on entry to WAIT.
- Undefined: WAIT waits indefinitely. ERR_BIT is always passed through unchanged. No counter logic is present.

Decomposition:
- Package uart_ctrl_pkg holds:
  - the state enum (IDLE, START, WAIT, CLEAR)
  - the bit-index localparams SEND/NEW_RX/OVR/ERR
  - the byte width constant
- Natural sub-module: module_uart_ctrl_timeout, a load/count/expire counter. It is instantiated only under UART_CTRL_TIMEOUT_EN.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n_i=0 for 2 cycles, ctrl_reg_i=0.
  - Required: all outputs 0, busy_o=0, no tx_start_o for 20 cycles.
- Single TX:
  - Stimulus: ctrl_reg_i=0x1 at N; tx_done_i at N+10; bench models the register.
  - Required: tx_start_o pulse at N+1 only; we_fsm_o at N+11 with instruccion_fsm_o=0x0; no second tx_start_o.
- RX capture:
  - Stimulus: rx_valid_i with rx_data_i=0xA5, ctrl_reg_i=0x0.
  - Required: rx_data_o=0xA5 next cycle; we_fsm_o=1 with instruccion_fsm_o=0x2.
- Overrun:
  - Stimulus: ctrl_reg_i=0x2, rx_valid_i with rx_data_i=0x3C.
  - Required: rx_data_o=0x3C; write value 0x6.
- Merge:
  - Stimulus: ctrl_reg_i=0x1; rx_valid_i in the same cycle as tx_done_i.
  - Required: single write cycle with instruccion_fsm_o=0x2.
- Timeout (macro on, TIMEOUT_CYCLES=16):
  - Stimulus: ctrl_reg_i=0x1, no tx_done_i.
  - Required: write 0x8 after 16 WAIT cycles; then IDLE.
- Mid-operation reset:
  - Stimulus: rst_n_i=0 while in WAIT.
  - Required: IDLE and no write-back.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// Shared types and bit positions for the UART control-register sequencer.
// Bit indices locate the command/status flags within the control register.
package uart_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_CLEAR = 2'd3
   } state_e;

   localparam int SEND_BIT   = 0;
   localparam int NEW_RX_BIT = 1;
   localparam int OVR_BIT    = 2;
   localparam int ERR_BIT    = 3;
   localparam int BYTE_W     = 8;

endpackage

// File: rtl/module_uart_ctrl_timeout.sv
// TX watchdog: load clears the count, en advances it, expired_o flags the LIMIT-th enabled cycle.
// Only compiled with UART_CTRL_TIMEOUT_EN; no backpressure, purely combinational expiry.
`ifdef UART_CTRL_TIMEOUT_EN
module module_uart_ctrl_timeout #(
   parameter int LIMIT = 200000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic load_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = en_i && (count_q == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/module_uart_ctrl_fsm.sv
// Sequences TX launches and RX captures, writing status back through the priority FSM port; 1-cycle
// latency from SEND/rx_valid to action, no backpressure. TX watchdog enabled by UART_CTRL_TIMEOUT_EN.
module module_uart_ctrl_fsm
   import uart_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
`ifdef UART_CTRL_TIMEOUT_EN
  ,parameter int TIMEOUT_CYCLES = 200000
`endif
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [DATA_W-1:0] ctrl_reg_i,
   input  logic              tx_done_i,
   input  logic              rx_valid_i,
   input  logic [BYTE_W-1:0] rx_data_i,
   output logic              tx_start_o,
   output logic              we_fsm_o,
   output logic [DATA_W-1:0] instruccion_fsm_o,
   output logic [BYTE_W-1:0] rx_data_o,
   output logic              busy_o
);

   state_e            state_q, state_d;
   logic [BYTE_W-1:0] rx_data_q, rx_data_d;
   logic              rx_pend_q, rx_pend_d;
   logic              ovr_pend_q, ovr_pend_d;
   logic [DATA_W-1:0] wr_val;
   logic              we;

`ifdef UART_CTRL_TIMEOUT_EN
   logic err_pend_q, err_pend_d;
   logic tmo_expired;

   module_uart_ctrl_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .load_i    (state_q == ST_START),
      .en_i      (state_q == ST_WAIT),
      .expired_o (tmo_expired)
   );
`endif

   always_comb begin
      state_d   = state_q;
      rx_data_d = rx_valid_i ? rx_data_i : rx_data_q;
      rx_pend_d = rx_valid_i;
      // A byte still unacknowledged in the register, or one whose NEW_RX write is only now landing, is overrun.
      ovr_pend_d = rx_valid_i & (ctrl_reg_i[NEW_RX_BIT] | rx_pend_q);
`ifdef UART_CTRL_TIMEOUT_EN
      err_pend_d = 1'b0;
`endif

      case (state_q)
         ST_IDLE:  if (ctrl_reg_i[SEND_BIT]) state_d = ST_START;
         ST_START: state_d = ST_WAIT;
         ST_WAIT: begin
            if (tx_done_i) begin
               state_d = ST_CLEAR;
`ifdef UART_CTRL_TIMEOUT_EN
            end else if (tmo_expired) begin
               state_d    = ST_CLEAR;
               err_pend_d = 1'b1;
`endif
            end
         end
         ST_CLEAR: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      wr_val = ctrl_reg_i;
      if (state_q == ST_CLEAR) wr_val[SEND_BIT]   = 1'b0;
      if (rx_pend_q)           wr_val[NEW_RX_BIT] = 1'b1;
      if (ovr_pend_q)          wr_val[OVR_BIT]    = 1'b1;
      we = (state_q == ST_CLEAR) | rx_pend_q | ovr_pend_q;
`ifdef UART_CTRL_TIMEOUT_EN
      if (err_pend_q) wr_val[ERR_BIT] = 1'b1;
      we = we | err_pend_q;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         rx_data_q  <= '0;
         rx_pend_q  <= 1'b0;
         ovr_pend_q <= 1'b0;
`ifdef UART_CTRL_TIMEOUT_EN
         err_pend_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rx_data_q  <= rx_data_d;
         rx_pend_q  <= rx_pend_d;
         ovr_pend_q <= ovr_pend_d;
`ifdef UART_CTRL_TIMEOUT_EN
         err_pend_q <= err_pend_d;
`endif
      end
   end

   assign tx_start_o        = (state_q == ST_START);
   assign we_fsm_o          = we;
   assign instruccion_fsm_o = we ? wr_val : '0;
   assign rx_data_o         = rx_data_q;
   assign busy_o            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_module_uart_ctrl_fsm.sv
// Scoreboard bench for module_uart_ctrl_fsm with a behavioural model of the control register.
module tb_module_uart_ctrl_fsm;
   import uart_ctrl_pkg::*;

   localparam int DATA_W = 32;

   typedef struct {
      int          cyc;
      logic [31:0] val;
      logic [7:0]  rxd;
   } wr_exp_t;

   logic              clk_i = 1'b0;
   logic              rst_n_i = 1'b0;
   logic [DATA_W-1:0] ctrl_reg_i;
   logic              tx_done_i = 1'b0;
   logic              rx_valid_i = 1'b0;
   logic [7:0]        rx_data_i = '0;
   logic              tx_start_o;
   logic              we_fsm_o;
   logic [DATA_W-1:0] instruccion_fsm_o;
   logic [7:0]        rx_data_o;
   logic              busy_o;

   logic [DATA_W-1:0] ctrl_reg = '0;
   logic              cpu_we = 1'b0;
   logic [DATA_W-1:0] cpu_val = '0;
   int                cyc = 0;
   int                checks = 0;
   int                failures = 0;

   int      start_q[$];
   wr_exp_t wr_q[$];

   always #5 clk_i = ~clk_i;

   module_uart_ctrl_fsm #(
      .DATA_W (DATA_W)
`ifdef UART_CTRL_TIMEOUT_EN
     ,.TIMEOUT_CYCLES (16)
`endif
   ) dut (
      .clk_i             (clk_i),
      .rst_n_i           (rst_n_i),
      .ctrl_reg_i        (ctrl_reg_i),
      .tx_done_i         (tx_done_i),
      .rx_valid_i        (rx_valid_i),
      .rx_data_i         (rx_data_i),
      .tx_start_o        (tx_start_o),
      .we_fsm_o          (we_fsm_o),
      .instruccion_fsm_o (instruccion_fsm_o),
      .rx_data_o         (rx_data_o),
      .busy_o            (busy_o)
   );

   // Control register: reset clears it, FSM port wins over the micro port.
   assign ctrl_reg_i = ctrl_reg;
   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      if (!rst_n_i)      ctrl_reg <= '0;
      else if (we_fsm_o) ctrl_reg <= instruccion_fsm_o;
      else if (cpu_we)   ctrl_reg <= cpu_val;
   end

   // Monitor: every observed pulse/write must match the head of its queue.
   always @(negedge clk_i) begin
      if (rst_n_i) begin
         if (tx_start_o) begin
            checks++;
            if (start_q.size() == 0) begin
               failures++;
               $display("FAIL tx_start: unexpected pulse at cycle %0d", cyc);
            end else begin
               int e;
               e = start_q.pop_front();
               if (e != cyc) begin
                  failures++;
                  $display("FAIL tx_start: pulse at cycle %0d, required cycle %0d", cyc, e);
               end
            end
         end
         if (we_fsm_o) begin
            checks++;
            if (wr_q.size() == 0) begin
               failures++;
               $display("FAIL write: unexpected write 0x%0h at cycle %0d", instruccion_fsm_o, cyc);
            end else begin
               wr_exp_t w;
               w = wr_q.pop_front();
               if (w.cyc != cyc || w.val != instruccion_fsm_o || w.rxd != rx_data_o) begin
                  failures++;
                  $display("FAIL write: got cyc=%0d val=0x%0h rxd=0x%0h, required cyc=%0d val=0x%0h rxd=0x%0h",
                           cyc, instruccion_fsm_o, rx_data_o, w.cyc, w.val, w.rxd);
               end
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // Returns the cycle in which the new register value is first visible.
   task automatic cpu_write(input logic [DATA_W-1:0] v, output int n);
      cpu_we = 1'b1;
      cpu_val = v;
      tick();
      cpu_we = 1'b0;
      n = cyc;
   endtask

   task automatic rx_byte(input logic [7:0] d);
      rx_valid_i = 1'b1;
      rx_data_i = d;
      tick();
      rx_valid_i = 1'b0;
   endtask

   task automatic expect_wr(input int c, input logic [31:0] v, input logic [7:0] d);
      wr_exp_t w;
      w.cyc = c;
      w.val = v;
      w.rxd = d;
      wr_q.push_back(w);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
      end
   endtask

   initial begin
      int n;
      int k;

      // Reset then idle
      tick(2);
      @(negedge clk_i);
      chk("rst_tx_start", {31'b0, tx_start_o}, 0);
      chk("rst_we", {31'b0, we_fsm_o}, 0);
      chk("rst_instr", instruccion_fsm_o, 0);
      chk("rst_rx_data", {24'b0, rx_data_o}, 0);
      chk("rst_busy", {31'b0, busy_o}, 0);
      tick();
      rst_n_i = 1'b1;
      tick(20);
      chk("idle_busy", {31'b0, busy_o}, 0);

      // Single TX
      cpu_write(32'h1, n);
      start_q.push_back(n + 1);
      tick(10);
      chk("wait_busy", {31'b0, busy_o}, 1);
      tx_done_i = 1'b1;
      expect_wr(n + 11, 32'h0, 8'h00);
      tick();
      tx_done_i = 1'b0;
      tick(10);
      chk("tx_done_busy", {31'b0, busy_o}, 0);

      // RX capture
      k = cyc;
      expect_wr(k + 1, 32'h2, 8'hA5);
      rx_byte(8'hA5);
      tick(3);
      cpu_write(32'h0, n);
      tick(2);

      // Overrun on unacknowledged byte
      cpu_write(32'h2, n);
      k = cyc;
      expect_wr(k + 1, 32'h6, 8'h3C);
      rx_byte(8'h3C);
      tick(3);
      cpu_write(32'h0, n);
      tick(2);

      // Back-to-back bytes
      k = cyc;
      expect_wr(k + 1, 32'h2, 8'h11);
      expect_wr(k + 2, 32'h6, 8'h22);
      rx_byte(8'h11);
      rx_byte(8'h22);
      tick(3);
      cpu_write(32'h0, n);
      tick(2);

      // RX coinciding with tx_done merges into one write
      cpu_write(32'h1, n);
      start_q.push_back(n + 1);
      tick(5);
      tx_done_i = 1'b1;
      rx_valid_i = 1'b1;
      rx_data_i = 8'h5A;
      expect_wr(n + 6, 32'h2, 8'h5A);
      tick();
      tx_done_i = 1'b0;
      rx_valid_i = 1'b0;
      tick(3);
      cpu_write(32'h0, n);
      tick(2);

`ifdef UART_CTRL_TIMEOUT_EN
      // Watchdog expiry after 16 WAIT cycles
      cpu_write(32'h1, n);
      start_q.push_back(n + 1);
      expect_wr(n + 18, 32'h8, 8'h5A);
      tick(20);
      chk("tmo_idle", {31'b0, busy_o}, 0);
      cpu_write(32'h0, n);
      tick(2);
`else
      // WAIT holds indefinitely without tx_done
      cpu_write(32'h1, n);
      start_q.push_back(n + 1);
      tick(40);
      chk("wait_hold_busy", {31'b0, busy_o}, 1);
      tx_done_i = 1'b1;
      expect_wr(cyc + 1, 32'h0, 8'h5A);
      tick();
      tx_done_i = 1'b0;
      tick(3);
      chk("wait_hold_done", {31'b0, busy_o}, 0);
`endif

      // Reset while waiting: no write-back, late tx_done ignored
      cpu_write(32'h1, n);
      start_q.push_back(n + 1);
      tick(3);
      chk("mid_busy", {31'b0, busy_o}, 1);
      rst_n_i = 1'b0;
      tick(2);
      rst_n_i = 1'b1;
      chk("mid_rst_busy", {31'b0, busy_o}, 0);
      chk("mid_rst_rx_data", {24'b0, rx_data_o}, 0);
      tx_done_i = 1'b1;
      tick();
      tx_done_i = 1'b0;
      tick(10);
      chk("post_rst_busy", {31'b0, busy_o}, 0);

      chk("start_q_empty", start_q.size(), 0);
      chk("wr_q_empty", wr_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
